// File: rtl/mips_defs.sv
// Shared MIPS encodings for the writeback stage: opcode/funct values, field widths, fixed registers.
package mips_defs;
  localparam int OPC_W  = 6;
  localparam int FN_W   = 6;
  localparam int REG_W  = 5;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPC_W-1:0] OP_LB    = 6'h20;
  localparam logic [OPC_W-1:0] OP_LH    = 6'h21;
  localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OP_LBU   = 6'h24;
  localparam logic [OPC_W-1:0] OP_LHU   = 6'h25;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FN_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FN_W-1:0] FN_JR   = 6'h08;
  localparam logic [FN_W-1:0] FN_JALR = 6'h09;
  localparam logic [FN_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FN_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FN_W-1:0] FN_AND  = 6'h24;
  localparam logic [FN_W-1:0] FN_OR   = 6'h25;
  localparam logic [FN_W-1:0] FN_SLT  = 6'h2A;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LOAD,
    SRC_LINK
  } wb_src_e;
endpackage

// File: rtl/reg_file_2r1w.sv
// 32x32 register file, one write port, two combinational read ports with write-through bypass.
// Write lands on the clock edge; reads are zero-latency; no backpressure.
module reg_file_2r1w
  import mips_defs::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic [REG_W-1:0] raddr_a,
  input  logic [REG_W-1:0] raddr_b,
  output logic [XLEN-1:0]  rdata_a,
  output logic [XLEN-1:0]  rdata_b
);
  // $0 has no storage; it is hardwired to zero on both read ports.
  logic [XLEN-1:0] mem [1:NREGS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) mem[i] <= '0;
    end else if (we && waddr != REG_ZERO) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (raddr_a != REG_ZERO) rdata_a = (we && raddr_a == waddr) ? wdata : mem[raddr_a];
    if (raddr_b != REG_ZERO) rdata_b = (we && raddr_b == waddr) ? wdata : mem[raddr_b];
  end
endmodule

// File: rtl/wb_commit.sv
// Writeback commit: decodes instrW, extends loads, writes the register file and counts retirements.
// Commit outputs are combinational, architectural update one edge later; no backpressure.
module wb_commit
  import mips_defs::*;
#(
  parameter int              RETIRE_W = 32,
  parameter logic [REG_W-1:0] LINK_REG = 5'd31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     instrW,
  input  logic [XLEN-1:0]     read_dataW,
  input  logic [XLEN-1:0]     alu_outW,
  input  logic [XLEN-1:0]     pc_plus8W,
  input  logic [REG_W-1:0]    rs_addr,
  input  logic [REG_W-1:0]    rt_addr,
  output logic [XLEN-1:0]     rs_data,
  output logic [XLEN-1:0]     rt_data,
  output logic                reg_write_en,
  output logic [REG_W-1:0]    reg_write_addr,
  output logic [XLEN-1:0]     reg_write_data,
  output logic [RETIRE_W-1:0] retired_count
);
  logic [OPC_W-1:0] op;
  logic [FN_W-1:0]  fn;
  logic [REG_W-1:0] rt, rd, dest;
  wb_src_e          src;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  ld_val, wb_val;
  logic             unused_fields;

  assign op = instrW[31:26];
  assign fn = instrW[5:0];
  assign rt = instrW[20:16];
  assign rd = instrW[15:11];
  assign unused_fields = ^{instrW[25:21], instrW[10:6]};

  always_comb begin
    src  = SRC_NONE;
    dest = REG_ZERO;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL: begin src = SRC_ALU;  dest = rd; end
          FN_JALR:                                         begin src = SRC_LINK; dest = rd; end
          default: ;
        endcase
      end
      OP_ADDIU, OP_ORI, OP_LUI:                 begin src = SRC_ALU;  dest = rt; end
      OP_JAL:                                   begin src = SRC_LINK; dest = LINK_REG; end
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU:      begin src = SRC_LOAD; dest = rt; end
      default: ;
    endcase
  end

  // Little-endian lane select; misaligned low bits are simply ignored.
  always_comb begin
    case (alu_outW[1:0])
      2'd0:    ld_byte = read_dataW[7:0];
      2'd1:    ld_byte = read_dataW[15:8];
      2'd2:    ld_byte = read_dataW[23:16];
      default: ld_byte = read_dataW[31:24];
    endcase
    ld_half = alu_outW[1] ? read_dataW[31:16] : read_dataW[15:0];
    case (op)
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'd0, ld_byte};
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'd0, ld_half};
      default: ld_val = read_dataW;
    endcase
  end

  always_comb begin
    case (src)
      SRC_ALU:  wb_val = alu_outW;
      SRC_LOAD: wb_val = ld_val;
      SRC_LINK: wb_val = pc_plus8W;
      default:  wb_val = '0;
    endcase
  end

  // Address and data are forced to zero when nothing commits so a bubble reads all-zero.
  assign reg_write_en   = (src != SRC_NONE) && (dest != REG_ZERO);
  assign reg_write_addr = reg_write_en ? dest : REG_ZERO;
  assign reg_write_data = reg_write_en ? wb_val : '0;

  reg_file_2r1w u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (reg_write_en),
    .waddr   (reg_write_addr),
    .wdata   (reg_write_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_count <= '0;
    end else if (instrW != '0) begin
      retired_count <= retired_count + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_wb_commit.sv
// Randomized and directed bench for wb_commit against an instruction-level reference model.
module tb_wb_commit;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instrW, read_dataW, alu_outW, pc_plus8W;
  logic [4:0]    rs_addr, rt_addr;
  logic [31:0]   rs_data, rt_data;
  logic          reg_write_en;
  logic [4:0]    reg_write_addr;
  logic [31:0]   reg_write_data;
  logic [RW-1:0] retired_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_regs [32];
  int unsigned model_cnt;

  always #5 clk = ~clk;

  wb_commit #(.RETIRE_W(RW), .LINK_REG(5'd31)) dut (
    .clk(clk), .reset(reset), .instrW(instrW), .read_dataW(read_dataW),
    .alu_outW(alu_outW), .pc_plus8W(pc_plus8W), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .reg_write_en(reg_write_en),
    .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .retired_count(retired_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rd, input int fn);
    logic [31:0] v;
    v = (32'(rd & 31) << 11) | 32'(fn & 63) | (32'd3 << 21) | (32'd4 << 16);
    return v;
  endfunction

  function automatic logic [31:0] itype(input int op, input int rt);
    logic [31:0] v;
    v = (32'(op & 63) << 26) | (32'(rt & 31) << 16) | (32'd2 << 21) | 32'h0000_0044;
    return v;
  endfunction

  // Instruction-level reference: what the architectural commit should be.
  task automatic model_commit(input logic [31:0] ins, rdw, alu, pc8,
                              output bit en, output logic [4:0] a, output logic [31:0] d);
    int op, fn, rt, rd, dst;
    int unsigned b, h;
    logic [31:0] val;
    bit wr;
    op = int'(ins >> 26); fn = int'(ins & 63);
    rt = int'((ins >> 16) & 31); rd = int'((ins >> 11) & 31);
    b  = (rdw >> (8 * (alu & 3))) & 32'hFF;
    h  = (rdw >> (16 * ((alu >> 1) & 1))) & 32'hFFFF;
    wr = 1; dst = 0; val = 0;
    case (op)
      0: begin
        dst = rd;
        if (fn == 'h21 || fn == 'h23 || fn == 'h24 || fn == 'h25 || fn == 'h2A || fn == 0) val = alu;
        else if (fn == 9) val = pc8;
        else wr = 0;
      end
      'h09, 'h0D, 'h0F: begin dst = rt; val = alu; end
      'h03: begin dst = 31; val = pc8; end
      'h23: begin dst = rt; val = rdw; end
      'h20: begin dst = rt; val = (b >= 128) ? (b | 32'hFFFF_FF00) : b; end
      'h24: begin dst = rt; val = b; end
      'h21: begin dst = rt; val = (h >= 32768) ? (h | 32'hFFFF_0000) : h; end
      'h25: begin dst = rt; val = h; end
      default: wr = 0;
    endcase
    en = wr && dst != 0;
    a  = en ? 5'(dst) : 5'd0;
    d  = en ? val : 32'd0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 0;
    model_cnt = 0;
  endtask

  task automatic step(input string tag, input logic [31:0] ins, rdw, alu, pc8,
                      input logic [4:0] ra, rb, input bit has_exp, input logic [31:0] exp_d);
    bit en;
    logic [4:0] a;
    logic [31:0] d, ea, eb;
    @(negedge clk);
    instrW = ins; read_dataW = rdw; alu_outW = alu; pc_plus8W = pc8;
    rs_addr = ra; rt_addr = rb;
    #1;
    model_commit(ins, rdw, alu, pc8, en, a, d);
    ea = (en && a == ra) ? d : model_regs[ra];
    eb = (en && a == rb) ? d : model_regs[rb];
    check({tag, ".en"},   {31'd0, reg_write_en}, {31'd0, en});
    check({tag, ".addr"}, {27'd0, reg_write_addr}, {27'd0, a});
    check({tag, ".data"}, reg_write_data, d);
    check({tag, ".rs"},   rs_data, ea);
    check({tag, ".rt"},   rt_data, eb);
    if (has_exp) check({tag, ".value"}, reg_write_data, exp_d);
    @(posedge clk);
    if (en) model_regs[a] = d;
    if (ins != 0) model_cnt = (model_cnt + 1) % (1 << RW);
    #1;
    check({tag, ".cnt"}, {28'd0, retired_count}, model_cnt);
  endtask

  task automatic rand_instr(output logic [31:0] ins);
    int k;
    logic [31:0] r;
    r = $urandom();
    k = $urandom_range(0, 17);
    case (k)
      0: ins = 0;
      1: ins = (r & 32'h03FF_F800) | 32'h21;
      2: ins = (r & 32'h03FF_F800) | 32'h23;
      3: ins = (r & 32'h03FF_F800) | 32'h2A;
      4: ins = (r & 32'h03FF_F800) | 32'h09;
      5: ins = (r & 32'h03FF_F800) | 32'h08;
      6: ins = (r & 32'h03FF_F800) | 32'h3F;
      7: ins = (r & 32'h03FF_FFFF) | (32'h09 << 26);
      8: ins = (r & 32'h03FF_FFFF) | (32'h0F << 26);
      9: ins = (r & 32'h03FF_FFFF) | (32'h03 << 26);
      10: ins = (r & 32'h03FF_FFFF) | (32'h23 << 26);
      11: ins = (r & 32'h03FF_FFFF) | (32'h20 << 26);
      12: ins = (r & 32'h03FF_FFFF) | (32'h24 << 26);
      13: ins = (r & 32'h03FF_FFFF) | (32'h21 << 26);
      14: ins = (r & 32'h03FF_FFFF) | (32'h25 << 26);
      15: ins = (r & 32'h03FF_FFFF) | (32'h2B << 26);
      16: ins = (r & 32'h03FF_FFFF) | (32'h04 << 26);
      default: ins = (r & 32'h03FF_FFFF) | (32'h3E << 26);
    endcase
  endtask

  initial begin
    logic [31:0] ins;
    reset = 1'b1;
    instrW = 0; read_dataW = 0; alu_outW = 0; pc_plus8W = 0; rs_addr = 0; rt_addr = 0;
    model_reset();
    #3;
    check("reset.cnt", {28'd0, retired_count}, 0);
    check("reset.en", {31'd0, reg_write_en}, 0);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); #1;
      check($sformatf("reset.r%0d", i), rs_data, 0);
    end
    @(negedge clk); reset = 1'b0;

    step("ori5", itype('h0D, 5), 0, 32'h1234, 0, 5, 5, 1, 32'h0000_1234);
    step("ori5.rd", 0, 0, 0, 0, 5, 0, 0, 0);
    check("ori5.arr", rs_data, 32'h0000_1234);

    step("lb2",  itype('h20, 10), 32'h80FF_7F01, 32'h102, 0, 10, 1, 1, 32'hFFFF_FFFF);
    step("lbu3", itype('h24, 11), 32'h80FF_7F01, 32'h103, 0, 11, 10, 1, 32'h0000_0080);
    step("lh0",  itype('h21, 12), 32'h80FF_7F01, 32'h100, 0, 12, 11, 1, 32'h0000_7F01);
    step("lh2",  itype('h21, 13), 32'h80FF_7F01, 32'h102, 0, 13, 12, 1, 32'hFFFF_80FF);
    step("lhu2", itype('h25, 14), 32'h80FF_7F01, 32'h102, 0, 14, 13, 1, 32'h0000_80FF);
    step("lw",   itype('h23, 15), 32'h80FF_7F01, 32'h101, 0, 15, 14, 1, 32'h80FF_7F01);

    step("jal",  32'h0C00_0100, 0, 32'h77, 32'h0000_3008, 31, 31, 1, 32'h0000_3008);
    step("jalr", rtype(7, 9), 0, 32'h77, 32'h0000_4444, 7, 31, 1, 32'h0000_4444);
    step("jr",   rtype(0, 8), 0, 32'h77, 32'h0000_5555, 7, 31, 1, 32'h0);
    step("addiu0", itype('h09, 0), 0, 32'hDEAD, 0, 0, 0, 1, 32'h0);
    check("addiu0.r0", rs_data, 0);
    step("sw",   itype('h2B, 6), 32'h1, 32'h2, 0, 6, 7, 1, 32'h0);
    step("beq",  itype('h04, 6), 32'h1, 32'h2, 0, 6, 5, 1, 32'h0);
    step("bub",  0, 32'h1, 32'h2, 32'h3, 7, 31, 1, 32'h0);

    step("b2b.a", itype('h09, 3), 0, 32'hAAAA_0001, 0, 3, 3, 1, 32'hAAAA_0001);
    step("b2b.b", itype('h09, 3), 0, 32'hBBBB_0002, 0, 3, 4, 1, 32'hBBBB_0002);
    step("b2b.rd", 0, 0, 0, 0, 3, 3, 0, 0);
    check("b2b.last", rs_data, 32'hBBBB_0002);

    // Asynchronous reset between edges: takes effect immediately.
    @(negedge clk); #1; reset = 1'b1; rs_addr = 5; #1;
    check("areset.r5", rs_data, 0);
    check("areset.cnt", {28'd0, retired_count}, 0);
    @(negedge clk); reset = 1'b0; model_reset();

    step("pre9", itype('h09, 9), 0, 32'h0000_0999, 0, 9, 0, 0, 0);
    // Reset lands while lw $9 sits in WB; the pending commit must be dropped.
    @(negedge clk);
    instrW = itype('h23, 9); read_dataW = 32'h5555_AAAA; alu_outW = 0;
    #2; reset = 1'b1;
    @(posedge clk); #1; instrW = 0; rs_addr = 9; #1;
    check("midrst.r9", rs_data, 0);
    check("midrst.cnt", {28'd0, retired_count}, 0);
    @(negedge clk); reset = 1'b0; model_reset();

    for (int i = 0; i < 17; i++) step("wrap", itype('h2B, 1), 0, 0, 0, 0, 0, 0, 0);
    check("wrap.cnt", {28'd0, retired_count}, 1);

    for (int i = 0; i < 400; i++) begin
      rand_instr(ins);
      step("rnd", ins, $urandom(), $urandom(), $urandom(),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 0, 0);
    end
    for (int i = 0; i < 32; i++) begin
      step("final", 0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
